// File: rtl/rv32_uart_rx.sv
// -----------------------------------------------------------------------------
// rv32_uart_rx
// UART receive front end for the RV32 serial port. RsRx is oversampled 16x.
// The block assembles 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) into
// little-endian 32-bit words and hands each word to the core with valid/ready.
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit per frame)
//
// Parameters
//   CLK_HZ        system clock frequency in Hz
//   BAUD          line rate in bits per second
//   TIMEOUT_BITS  idle bit-times after which a partial word is flushed
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   RsRx         serial line, asynchronous to clk, idles high
//   data_rx      assembled word, byte k in bits [8k+7:8k]
//   rx_valid     data_rx / rx_bytes are valid
//   rx_ready     consumer accepts the word
//   rx_bytes     number of valid bytes in the word (1-4)
//   frame_err    one-cycle pulse on a bad stop bit (or bad parity)
//   overrun      one-cycle pulse when a completed word is dropped
//   o_dbg_state  current receive FSM state
//
// Handshake: a word transfers on every rising edge where rx_valid && rx_ready.
// While rx_valid is high and rx_ready is low, data_rx and rx_bytes hold stable.
// -----------------------------------------------------------------------------
module rv32_uart_rx #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RsRx,
   output logic [31:0] data_rx,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [2:0]  rx_bytes,
   output logic        frame_err,
   output logic        overrun,
   output logic [2:0]  o_dbg_state
);

   localparam int DIV      = CLK_HZ / (BAUD * 16);
   localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TO_TICKS = TIMEOUT_BITS * 16;
   localparam int TO_W     = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_rx_meta;
   logic              r_rxs;
   logic [DIV_W-1:0]  r_div_cnt;
   logic              w_tick;
   logic [3:0]        r_tick_cnt;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              r_err_hold;
   logic              w_par_bad;

   logic              w_start;
   logic              w_bit_end;
   logic              w_byte_good;
   logic              w_ferr;

   logic [31:0]       r_buf;
   logic [2:0]        r_byte_cnt;
   logic [31:0]       w_buf_wr;
   logic [TO_W-1:0]   r_to_cnt;
   logic              w_word_full;
   logic              w_flush;
   logic              w_load;
   logic [31:0]       w_load_word;
   logic [2:0]        w_load_bytes;

   logic [31:0]       r_data_rx;
   logic              r_rx_valid;
   logic [2:0]        r_rx_bytes;
   logic              r_frame_err;
   logic              r_overrun;

   // ---------------- synchronizer (idle-high reset value) ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= RsRx;
         r_rxs     <= r_rx_meta;
      end
   end

   // ---------------- 16x tick generator ----------------
   // Restarted on start-bit detection so the mid-bit samples line up with
   // the detected falling edge rather than a free-running phase.
   assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_div_cnt <= '0;
      else if (w_start || w_tick) r_div_cnt <= '0;
      else                        r_div_cnt <= r_div_cnt + 1'b1;
   end

   // ---------------- receive FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_byte_good = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // After a framing error the line must return high before re-arming,
            // otherwise a stuck-low line would retrigger endlessly.
            if (!r_err_hold && !r_rxs) begin
               w_state_nxt = S_START;
               w_start     = 1'b1;
            end
         end
         S_START: begin
            if (w_tick && (r_tick_cnt == 4'd7))
               w_state_nxt = r_rxs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_bit_end && (r_bit_idx == 3'd7))
`ifdef UART_RX_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) w_state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt = S_IDLE;
               if (r_rxs && !w_par_bad) w_byte_good = 1'b1;
               else                     w_ferr      = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bit-phase counter restarts on every state change; in DATA it wraps
   // 15 -> 0 by itself between consecutive bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_tick_cnt <= 4'd0;
      else if (r_state != w_state_nxt)     r_tick_cnt <= 4'd0;
      else if (w_tick && r_state != S_IDLE) r_tick_cnt <= r_tick_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_idx   <= 3'd0;
         r_shift     <= 8'd0;
         r_err_hold  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_ferr;
         if (w_start)
            r_bit_idx <= 3'd0;
         else if (r_state == S_DATA && w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            r_shift   <= {r_rxs, r_shift[7:1]};   // LSB first
         end
         if (w_ferr)                         r_err_hold <= 1'b1;
         else if (r_state == S_IDLE && r_rxs) r_err_hold <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_bad;

   // Even parity: data bits plus parity bit must hold an even number of ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_par_bad <= 1'b0;
      else if (w_start)                          r_par_bad <= 1'b0;
      else if (r_state == S_PARITY && w_bit_end) r_par_bad <= r_rxs ^ (^r_shift);
   end

   assign w_par_bad = r_par_bad;
`else
   assign w_par_bad = 1'b0;
`endif

   // ---------------- word assembly ----------------
   always_comb begin
      w_buf_wr = r_buf;
      w_buf_wr[8*r_byte_cnt[1:0] +: 8] = r_shift;
   end

   assign w_word_full  = w_byte_good && (r_byte_cnt == 3'd3);
   // Only possible in IDLE, so it never coincides with a byte completion.
   assign w_flush      = (r_state == S_IDLE) && !w_start && (r_byte_cnt != 3'd0) &&
                         w_tick && (r_to_cnt == TO_W'(TO_TICKS - 1));
   assign w_load       = w_word_full || w_flush;
   assign w_load_word  = w_word_full ? w_buf_wr : r_buf;
   assign w_load_bytes = w_word_full ? 3'd4 : r_byte_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf      <= 32'd0;
         r_byte_cnt <= 3'd0;
      end else if (w_load) begin
         // Cleared buffer guarantees unwritten lanes of a flushed word are 0.
         r_buf      <= 32'd0;
         r_byte_cnt <= 3'd0;
      end else if (w_byte_good) begin
         r_buf      <= w_buf_wr;
         r_byte_cnt <= r_byte_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     r_to_cnt <= '0;
      else if (w_start || w_flush || r_byte_cnt == 3'd0) r_to_cnt <= '0;
      else if (r_state == S_IDLE && w_tick)           r_to_cnt <= r_to_cnt + 1'b1;
   end

   // ---------------- output register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_rx  <= 32'd0;
         r_rx_valid <= 1'b0;
         r_rx_bytes <= 3'd0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_load) begin
            // A word arriving in the same cycle the held one is accepted
            // simply replaces it; only a still-blocked slot drops the new word.
            if (r_rx_valid && !rx_ready) begin
               r_overrun <= 1'b1;
            end else begin
               r_data_rx  <= w_load_word;
               r_rx_bytes <= w_load_bytes;
               r_rx_valid <= 1'b1;
            end
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign data_rx     = r_data_rx;
   assign rx_valid    = r_rx_valid;
   assign rx_bytes    = r_rx_bytes;
   assign frame_err   = r_frame_err;
   assign overrun     = r_overrun;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rv32_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_rv32_uart_rx
// Self-checking bench for rv32_uart_rx at CLK_HZ=16 MHz, BAUD=1 Mbaud (one bit
// is 16 clk). A reference model turns transmitted bytes into expected words
// (groups of four, or a flush after a long idle gap) and a scoreboard pops
// them on each handshake. Directed cases cover the named scenarios, then a
// randomized run mixes bytes, gaps, framing errors and consumer stalls.
// -----------------------------------------------------------------------------
module tb_rv32_uart_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RsRx;
   logic [31:0] data_rx;
   logic        rx_valid;
   logic        rx_ready;
   logic [2:0]  rx_bytes;
   logic        frame_err;
   logic        overrun;
   logic [2:0]  o_dbg_state;

   rv32_uart_rx #(
      .CLK_HZ       (16_000_000),
      .BAUD         (1_000_000),
      .TIMEOUT_BITS (40)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RsRx        (RsRx),
      .data_rx     (data_rx),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_bytes    (rx_bytes),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- counters and scoreboard ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   int          vld_cycles = 0;
   int          ferr_seen = 0;
   int          ovr_seen = 0;
   int          ferr_exp = 0;
   int          ovr_exp = 0;
   bit          stall = 1'b0;
   bit          rand_rdy = 1'b0;
   int          low_run = 0;
   logic [34:0] exp_q[$];     // {byte count, word}
   logic [7:0]  pend_q[$];    // bytes received but not yet forming a word
   logic [34:0] mon_e;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_flush();
      logic [31:0] w;
      w = 32'd0;
      foreach (pend_q[i]) w = w | (32'(pend_q[i]) << (8 * i));
      if (pend_q.size() != 0) begin
         if (stall && exp_q.size() != 0) ovr_exp++;
         else exp_q.push_back({3'(pend_q.size()), w});
      end
      pend_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      pend_q.push_back(b);
      if (pend_q.size() == 4) model_flush();
   endtask

   task automatic model_reset();
      exp_q.delete();
      pend_q.delete();
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after the falling edge; ready optionally
   // randomized with low stretches bounded well below one frame.
   task automatic tick_clk();
      @(negedge clk);
      #1;
      if (rand_rdy) begin
         if (!rx_ready && low_run >= 8) rx_ready = 1'b1;
         else rx_ready = ($urandom_range(0, 3) != 0);
         low_run = rx_ready ? 0 : low_run + 1;
      end
   endtask

   task automatic drive_bit(input logic v);
      RsRx = v;
      repeat (16) tick_clk();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^b);
`endif
      // Model updated before the stop bit so it leads the DUT's output.
      if (bad_stop) ferr_exp++;
      else model_byte(b);
      drive_bit(!bad_stop);
      RsRx = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (rx_valid)  vld_cycles++;
         if (frame_err) ferr_seen++;
         if (overrun)   ovr_seen++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_word", data_rx, 32'hFFFF_FFFF ^ data_rx);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("data_rx", data_rx, mon_e[31:0]);
               check_eq("rx_bytes", 32'(rx_bytes), 32'(mon_e[34:32]));
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_data_rx"},   data_rx, 32'd0);
      check_eq({tag, "_rx_valid"},  32'(rx_valid), 32'd0);
      check_eq({tag, "_rx_bytes"},  32'(rx_bytes), 32'd0);
      check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      check_eq({tag, "_overrun"},   32'(overrun), 32'd0);
      check_eq({tag, "_state"},     32'(o_dbg_state), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      bit         bad;
      int         v0, f0, o0;
      logic [7:0] t1[4];
      logic [7:0] t3[4];

      rst_n    = 1'b0;
      RsRx     = 1'b1;
      rx_ready = 1'b1;
      repeat (4) tick_clk();
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      repeat (4) tick_clk();
      check_reset_outputs("after_reset");

      // Four back-to-back bytes with ready held high.
      t1 = '{8'h78, 8'h56, 8'h34, 8'h12};
      v0 = vld_cycles;
      for (int i = 0; i < 4; i++) send_byte(t1[i], 1'b0);
      repeat (10) tick_clk();
      check_eq("word4_valid_cycles", 32'(vld_cycles - v0), 32'd1);
      check_eq("word4_drained", 32'(exp_q.size()), 32'd0);

      // Partial word flushed at the 640th idle tick after the last stop sample.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h3C, 1'b0);
      model_flush();
      repeat (634) tick_clk();
      check_eq("timeout_not_early", 32'(rx_valid), 32'd0);
      tick_clk();
      check_eq("timeout_flush", 32'(rx_valid), 32'd1);
      check_eq("timeout_bytes", 32'(rx_bytes), 32'd2);
      check_eq("timeout_data", data_rx, 32'h0000_3CA5);
      repeat (5) tick_clk();

      // Short low glitch is rejected silently.
      f0 = ferr_seen;
      v0 = vld_cycles;
      RsRx = 1'b0;
      repeat (5) tick_clk();
      RsRx = 1'b1;
      repeat (30) tick_clk();
      check_eq("glitch_no_ferr", 32'(ferr_seen - f0), 32'd0);
      check_eq("glitch_idle", 32'(o_dbg_state), 32'd0);
      check_eq("glitch_no_word", 32'(vld_cycles - v0), 32'd0);

      // Bad stop bit, then a clean word (also proves the glitch left no byte).
      f0 = ferr_seen;
      send_byte(8'h55, 1'b1);
      repeat (20) tick_clk();
      check_eq("ferr_pulse", 32'(ferr_seen - f0), 32'd1);
      t3 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < 4; i++) send_byte(t3[i], 1'b0);
      repeat (10) tick_clk();
      check_eq("after_ferr_drained", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
      // 0x01 with the parity bit driven wrong.
      f0 = ferr_seen;
      drive_bit(1'b0);
      b = 8'h01;
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      ferr_exp++;
      drive_bit(1'b0);
      drive_bit(1'b1);
      repeat (20) tick_clk();
      check_eq("parity_ferr", 32'(ferr_seen - f0), 32'd1);
`endif

      // Stalled consumer: second word is dropped with one overrun pulse.
      rx_ready = 1'b0;
      stall    = 1'b1;
      o0       = ovr_seen;
      for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      repeat (5) tick_clk();
      check_eq("overrun_pulse", 32'(ovr_seen - o0), 32'd1);
      check_eq("overrun_valid_held", 32'(rx_valid), 32'd1);
      if (exp_q.size() == 1) begin
         check_eq("overrun_data_held", data_rx, exp_q[0][31:0]);
         check_eq("overrun_bytes_held", 32'(rx_bytes), 32'(exp_q[0][34:32]));
      end else begin
         check_eq("overrun_model_depth", 32'(exp_q.size()), 32'd1);
      end
      stall    = 1'b0;
      rx_ready = 1'b1;
      repeat (5) tick_clk();
      check_eq("overrun_accepted", 32'(exp_q.size()), 32'd0);

      // Reset mid-byte while a word is held.
      rx_ready = 1'b0;
      stall    = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rst_n = 1'b0;
      model_reset();
      tick_clk();
      check_reset_outputs("mid_reset");
      RsRx = 1'b1;
      repeat (3) tick_clk();
      rst_n = 1'b1;
      repeat (10) tick_clk();
      stall    = 1'b0;
      rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      repeat (10) tick_clk();
      check_eq("post_reset_drained", 32'(exp_q.size()), 32'd0);

      // Randomized traffic with bounded ready stalls (no overrun expected).
      o0       = ovr_seen;
      rand_rdy = 1'b1;
      for (int n = 0; n < 60; n++) begin
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 9) == 0);
         send_byte(b, bad);
         if ($urandom_range(0, 7) == 0) begin
            model_flush();
            repeat ($urandom_range(650, 700)) tick_clk();
         end else if (bad) begin
            repeat ($urandom_range(20, 40)) tick_clk();
         end else begin
            repeat ($urandom_range(0, 40)) tick_clk();
         end
      end
      model_flush();
      repeat (700) tick_clk();
      rand_rdy = 1'b0;
      rx_ready = 1'b1;
      repeat (10) tick_clk();
      check_eq("random_no_overrun", 32'(ovr_seen - o0), 32'd0);
      check_eq("final_drained", 32'(exp_q.size()), 32'd0);
      check_eq("total_frame_err", 32'(ferr_seen), 32'(ferr_exp));
      check_eq("total_overrun", 32'(ovr_seen), 32'(ovr_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rv32_uart_rx.md
# rv32_uart_rx

UART receive front end for the RV32 core's serial port. It samples the `RsRx` line with 16x oversampling and assembles 8N1 frames (8E1 when parity is enabled) into 32-bit little-endian words. It presents each word on `data_rx` with a valid/ready handshake. It is the receive-side counterpart of the core's UART transmitter and replaces the raw `data_rx` register feeding the core's load path.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate in bits per second.
- `TIMEOUT_BITS`, 40, number of idle bit-times after which a partial word is flushed.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RsRx`  in  1  serial line; asynchronous to `clk`; idles high.
- `data_rx`  out  32  assembled word; byte k occupies bits [8k+7:8k].
- `rx_valid`  out  1  `data_rx` and `rx_bytes` are valid.
- `rx_ready`  in  1  consumer accepts the word.
- `rx_bytes`  out  3  number of valid bytes in the word, 1–4.
- `frame_err`  out  1  one-cycle pulse when the stop bit (or parity) is bad.
- `overrun`  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- **Synchronizer:** two flip-flops on `RsRx`; both reset to 1. All logic uses the synchronized value `rxs`.
- **Tick generator:** `DIV = CLK_HZ/(BAUD*16)`, integer-truncated (651 at the defaults). A counter runs from 0 to DIV-1 and emits one-cycle `tick` at DIV-1. The counter is cleared on the IDLE→START transition.
- **Receive FSM:** IDLE, START, DATA, PARITY (only when the macro is defined), STOP. A 4-bit tick counter and a 3-bit bit index are used.
  - IDLE: `rxs`==0 → START. After a framing error, IDLE first requires `rxs`==1 before it arms again.
  - START: at tick 7 (mid-bit), `rxs`==0 → DATA; otherwise it is a glitch → IDLE with no error.
  - DATA: every 16th tick, shift `rxs` into the byte, LSB first. After bit 7 → PARITY or STOP.
  - STOP: at the 16th tick, `rxs`==1 means the byte is good; `rxs`==0 means pulse `frame_err`, discard the byte, and go to IDLE.
- **Word assembly:**
  - Each good byte is written to lane `byte_cnt`, then `byte_cnt` increments.
  - At `byte_cnt`==4 the word is complete.
  - A timeout counter counts ticks while in IDLE with 1–3 bytes held. It is cleared on each start bit. At TIMEOUT_BITS*16 ticks it flushes a partial word; unwritten lanes are 0.
- **Output register:**
  - A completed or flushed word loads `data_rx`/`rx_bytes` and sets `rx_valid`.
  - These hold stable until a cycle with `rx_valid`&&`rx_ready`, which clears `rx_valid`.
  - If a new word completes while `rx_valid`&&!`rx_ready`, the new word is dropped, `overrun` pulses, and the held word is unchanged.
  - Completion in the same cycle as acceptance is not an overrun; the new word loads and `rx_valid` stays 1.
- **Reset values:** `data_rx`=0, `rx_valid`=0, `rx_bytes`=0, `frame_err`=0, `overrun`=0. The FSM goes to IDLE, and all counters and the assembly buffer clear. Reset mid-frame abandons the frame; reception resumes at the next falling edge after release.

## Timing
- Synchronizer latency is 2 clk.
- The start bit is validated 8 ticks after the detected edge. Data and stop bits are sampled at the bit centre, 16 ticks apart.
- `rx_valid` rises 1 clk after the stop-bit sample tick of the 4th byte (or after the timeout tick).
- `frame_err` and `overrun` are high for exactly one clk.
- Back-to-back frames are supported; the next start bit may begin immediately after the stop-bit centre.
- `rx_ready` may be held high permanently; each word is then accepted 1 clk after `rx_valid` rises.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state is present.
  - One even-parity bit is sampled after bit 7, at the 16th tick.
  - A mismatch pulses `frame_err` and discards the byte; the stop bit is still checked.
  - The frame is 11 bits.
- **Not defined:** 8N1, 10-bit frame; the PARITY state is absent.

## Test plan
Bench: `CLK_HZ`=16_000_000, `BAUD`=1_000_000, so `DIV`=1 and one bit is 16 clk.
- Send bytes 0x78, 0x56, 0x34, 0x12 back-to-back with `rx_ready`=1 → `data_rx`=0x12345678, `rx_bytes`=4, `rx_valid` high for 1 clk.
- Send 0xA5, 0x3C, then idle for 40 bit-times → `data_rx`=0x00003CA5, `rx_bytes`=2, flushed at exactly the 640th idle tick.
- Send 0x55 with the stop bit driven 0 → `frame_err` pulses once and nothing is assembled. Then send 0xDE, 0xAD, 0xBE, 0xEF → `data_rx`=0xEFBEADDE.
- Drive a 5-clk low glitch on `RsRx` → no `frame_err`, no byte, FSM back in IDLE.
- Hold `rx_ready`=0 and send 8 bytes → the first word is held unchanged and `overrun` pulses once at the second completion. Raise `rx_ready` → the first word is accepted.
- Assert `rst_n`=0 mid-byte, then release and send 4 bytes → outputs are at their reset values during reset and the following word assembles correctly. With `UART_RX_PARITY_EN`, a bad parity bit on 0x01 → `frame_err` pulses.
